// File: rtl/expr_gen.sv
// expr_gen: streams a random arithmetic expression, one ASCII character per transfer.
// Grammar: expr = term {op term}; term = digit | "(" digit {op digit} ")".
// Every decision for a character comes from a 16-bit Galois LFSR. The LFSR steps
// once per accepted character.
// Build option: define EXPR_GEN_PAREN_EN to enable parenthesised terms. When it is
// undefined, only flat digit/op strings are produced.
module expr_gen (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [3:0]  num_terms,
  input  logic [15:0] seed,
  output logic [7:0]  out_char,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] SeedDefault = 16'hACE1;
  localparam logic [15:0] LfsrMask    = 16'hB400;
  localparam logic [7:0]  CharLp      = 8'h28;
  localparam logic [7:0]  CharRp      = 8'h29;

  // The state names the kind of character currently presented on out_char.
  typedef enum logic [2:0] {StIdle, StDig, StOp, StLp, StIdig, StIop, StRp} state_e;

  state_e      state_q, state_d;
  logic [7:0]  char_q, char_d;
  logic        last_q, last_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  terms_q, terms_d;
  logic [2:0]  grp_q, grp_d;
  logic        done_q, done_d;

  logic        xfer;
  logic [15:0] lfsr_next, lsel, seed_eff;
  logic [3:0]  nt_eff, terms_cur;
  logic        paren;
  state_e      term_state;
  logic [7:0]  term_char;
  logic        term_last;
  logic [2:0]  term_grp;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ ({16{l[0]}} & LfsrMask);
  endfunction

  function automatic logic [7:0] digit_char(input logic [15:0] l);
    logic [3:0] r;
    r = (l[3:0] >= 4'd10) ? (l[3:0] - 4'd10) : l[3:0];
    return 8'h30 + {4'h0, r};
  endfunction

  function automatic logic [7:0] op_char(input logic [15:0] l);
    return l[4] ? 8'h2A : 8'h2B;
  endfunction

  function automatic logic paren_pick(input logic [15:0] l);
`ifdef EXPR_GEN_PAREN_EN
    return l[6] & l[5];
`else
    return 1'b0 & l[6];
`endif
  endfunction

  function automatic logic [2:0] grp_count(input logic [15:0] l);
    return {1'b0, l[8:7]} + 3'd1;
  endfunction

  // Decision inputs: the LFSR value the next loaded character will be built from.
  always_comb begin
    seed_eff   = (seed == 16'h0000) ? SeedDefault : seed;
    nt_eff     = (num_terms == 4'd0) ? 4'd1 : num_terms;
    lfsr_next  = lfsr_step(lfsr_q);
    xfer       = (state_q != StIdle) & out_ready;
    lsel       = (state_q == StIdle) ? seed_eff : lfsr_next;
    terms_cur  = (state_q == StIdle) ? nt_eff : terms_q;
    paren      = paren_pick(lsel);
    term_state = paren ? StLp : StDig;
    term_char  = paren ? CharLp : digit_char(lsel);
    term_last  = ~paren & (terms_cur == 4'd1);
    term_grp   = paren ? grp_count(lsel) : grp_q;
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      char_q  <= 8'h00;
      last_q  <= 1'b0;
      lfsr_q  <= SeedDefault;
      terms_q <= 4'd0;
      grp_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      last_q  <= last_d;
      lfsr_q  <= lfsr_d;
      terms_q <= terms_d;
      grp_q   <= grp_d;
      done_q  <= done_d;
    end
  end

  // Next state: load the following character on start or on a transfer, else hold.
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    last_d  = last_q;
    lfsr_d  = lfsr_q;
    terms_d = terms_q;
    grp_d   = grp_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lfsr_d  = seed_eff;
          terms_d = nt_eff;
          state_d = term_state;
          char_d  = term_char;
          last_d  = term_last;
          grp_d   = term_grp;
        end
      end
      StDig, StRp: begin
        if (xfer) begin
          lfsr_d  = lfsr_next;
          terms_d = terms_q - 4'd1;
          if (last_q) begin
            state_d = StIdle;
            char_d  = 8'h00;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StOp;
            char_d  = op_char(lsel);
            last_d  = 1'b0;
          end
        end
      end
      StOp: begin
        if (xfer) begin
          lfsr_d  = lfsr_next;
          state_d = term_state;
          char_d  = term_char;
          last_d  = term_last;
          grp_d   = term_grp;
        end
      end
      StLp, StIop: begin
        // grp_q counts group digits not yet loaded.
        if (xfer) begin
          lfsr_d  = lfsr_next;
          state_d = StIdig;
          char_d  = digit_char(lsel);
          grp_d   = grp_q - 3'd1;
        end
      end
      StIdig: begin
        if (xfer) begin
          lfsr_d = lfsr_next;
          if (grp_q != 3'd0) begin
            state_d = StIop;
            char_d  = op_char(lsel);
          end else begin
            state_d = StRp;
            char_d  = CharRp;
            last_d  = (terms_q == 4'd1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs straight from registers; a character is presented in every non-idle state.
  always_comb begin
    out_valid = (state_q != StIdle);
    busy      = (state_q != StIdle);
    out_char  = char_q;
    out_last  = last_q;
    done      = done_q;
  end

endmodule
